// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed 32-tap FIR controller.
// A single shared multiply-accumulate unit steps through every tap for each
// accepted sample. The sample history is a circular buffer and the
// coefficient bank is run-time writable while the block is idle.
module fir_mac_sequencer #(
  parameter int ORDER  = 32,
  parameter int IN_W   = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 21,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     coef_we,
  input  logic [$clog2(ORDER)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_drop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     busy
);

  localparam int AW = $clog2(ORDER);
  localparam int PW = IN_W + COEF_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(ORDER - 1);

  // Low-pass reset coefficients, 8-bit fields, b31 in the top byte.
  // The response is symmetric, so the list reads the same in either order.
  localparam logic [8*32-1:0] COEF_INIT = {
    8'd0,  8'd2,  8'd3,  8'd4,  8'd4,  8'd2,  8'd0,  8'd0,
    8'd0,  8'd0,  8'd0,  8'd5,  8'd18, 8'd32, 8'd44, 8'd50,
    8'd50, 8'd44, 8'd32, 8'd18, 8'd5,  8'd0,  8'd0,  8'd0,
    8'd0,  8'd0,  8'd2,  8'd4,  8'd4,  8'd3,  8'd2,  8'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // Reset value of coefficient k taken from the packed default table.
  function automatic logic [COEF_W-1:0] coef_reset_val(input int k);
    return COEF_W'(COEF_INIT[k*8 +: 8]);
  endfunction

  state_t              state_q, state_d;
  logic [AW-1:0]       wp_q, wp_d;
  logic [AW-1:0]       wp_s_q, wp_s_d;
  logic [AW-1:0]       tap_q, tap_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                coef_drop_q, coef_drop_d;
  logic [IN_W-1:0]     hist_q [ORDER];
  logic [IN_W-1:0]     hist_d [ORDER];
  logic [COEF_W-1:0]   coef_q [ORDER];
  logic [COEF_W-1:0]   coef_d [ORDER];

  logic                accept_s;
  logic [AW-1:0]       rd_idx_s;
  logic [PW-1:0]       prod_s;
  logic [ACC_W-1:0]    acc_sum_s;

  // Handshake and shared MAC datapath; the read index wraps naturally mod ORDER.
  always_comb begin
    accept_s  = in_valid && (state_q == ST_IDLE);
    rd_idx_s  = wp_s_q - tap_q;
    prod_s    = PW'(coef_q[tap_q]) * PW'(hist_q[rd_idx_s]);
    acc_sum_s = acc_q + ACC_W'(prod_s);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> 32 MAC cycles -> hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (tap_q == LAST_TAP) begin
          state_d = ST_OUTPUT;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values for each state.
  always_comb begin
    wp_d        = wp_q;
    wp_s_d      = wp_s_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    coef_drop_d = 1'b0;
    hist_d      = hist_q;
    coef_d      = coef_q;
    case (state_q)
      ST_IDLE: begin
        // A write in the accept cycle lands before tap 0 is read.
        if (coef_we) begin
          coef_d[coef_addr] = coef_wdata;
        end else begin
          coef_d = coef_q;
        end
        if (accept_s) begin
          hist_d[wp_q] = in_data;
          wp_s_d       = wp_q;
          wp_d         = wp_q + AW'(1);
          acc_d        = '0;
          tap_d        = '0;
        end else begin
          hist_d = hist_q;
        end
      end
      ST_ACCUM: begin
        coef_drop_d = coef_we;
        acc_d       = acc_sum_s;
        tap_d       = tap_q + AW'(1);
        if (tap_q == LAST_TAP) begin
          out_data_d  = acc_sum_s[OUT_W-1:0];
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_OUTPUT: begin
        coef_drop_d = coef_we;
        if (out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers, history buffer and coefficient bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      wp_s_q      <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_drop_q <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= coef_reset_val(i);
      end
    end else begin
      wp_q        <= wp_d;
      wp_s_q      <= wp_s_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      coef_drop_q <= coef_drop_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_drop = coef_drop_q;

endmodule
